fitness_eval_sequencer: RTL
===========================

# fitness_eval_sequencer

Hardware sequencer that scores a population of evolved candidate circuits against a stored test-vector set. Each candidate has four 16-bit inputs {a1,a0,b1,b0} and four 16-bit outputs {y3,y2,y1,y0}. The block fetches each vector and drives the shared candidate inputs. After a settle window it adds every candidate's bitwise output match count to a per-candidate accumulator. Once all vectors have been applied, it streams the final fitness scores out over a valid/ready interface. It sits between the test-vector memory, the array of candidate instances, and the host that collects fitness.

## Interface
- POP_SIZE, 15: number of candidate instances scored in parallel.
- TEST_COUNT, 2: number of test vectors in memory. Minimum is 1.
- DATA_W, 16: width of each candidate input and output signal.
- SETTLE_CYCLES, 1: number of cycles between applying inputs and sampling outputs. Minimum is 1.
- Derived FIT_W = clog2(TEST_COUNT*4*DATA_W+1), the score width. AW = max(1, clog2(TEST_COUNT)). IW = max(1, clog2(POP_SIZE)).

- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-low.
- start  in  1  run request. Sampled only in IDLE.
- vec_addr  out  AW  test-vector read address.
- vec_rdata  in  8*DATA_W  vector {a1,a0,b1,b0,y3,y2,y1,y0}, MSB first. Valid exactly 1 cycle after vec_addr.
- dut_in  out  4*DATA_W  {a1,a0,b1,b0} driven to all candidates.
- dut_out  in  POP_SIZE*4*DATA_W  candidate i occupies bits [i*4*DATA_W +: 4*DATA_W] as {y3,y2,y1,y0}.
- busy  out  1  high in every state except IDLE.
- fit_valid  out  1  a score is presented.
- fit_ready  in  1  consumer accepts the score.
- fit_index  out  IW  candidate index of the presented score.
- fit_score  out  FIT_W  accumulated match count.
- done  out  1  one-cycle pulse when the run ends.

## Operation
- States: IDLE, FETCH, LOAD, SETTLE, SCORE, DRAIN, DONE.
- IDLE
  - start=1 moves to FETCH.
  - Same cycle: clears all POP_SIZE accumulators, sets vec_addr=0, clears the vector counter.
- FETCH: holds vec_addr for one cycle, then goes to LOAD.
- LOAD
  - dut_in <= vec_rdata[8*DATA_W-1:4*DATA_W].
  - Internal expected register <= vec_rdata[4*DATA_W-1:0].
  - Loads the settle counter, then goes to SETTLE.
- SETTLE: stays SETTLE_CYCLES cycles, then goes to SCORE.
- SCORE (one cycle)
  - For every candidate i at once: acc[i] += popcount(~(dut_out_i ^ expected)), where each term is 0..4*DATA_W.
  - Not the last vector: vec_addr++ and go to FETCH.
  - Last vector: fit_index=0 and go to DRAIN.
- DRAIN
  - fit_valid=1, fit_score=acc[fit_index].
  - On fit_valid&&fit_ready, fit_index increments.
  - Handshake on index POP_SIZE-1 goes to DONE.
- DONE: done=1 for one cycle, then IDLE. fit_valid is 0 in DONE.
- start is ignored in every state except IDLE. No queuing.
- Accumulators never overflow, because FIT_W covers TEST_COUNT*4*DATA_W. No saturation logic is needed.
- dut_in keeps its last applied value after the run, until the next LOAD.

## Timing
- Reset (rst=0 at a clk edge) values: state=IDLE, busy=0, done=0, fit_valid=0, fit_index=0, fit_score=0, vec_addr=0, dut_in=0, all accumulators=0.
- Reset takes priority over all other events.
- Reset mid-run aborts immediately: no done pulse, fit_valid drops on the next cycle.
- If start is accepted at edge T:
  - busy=1 from T+1.
  - Each vector costs 3+SETTLE_CYCLES cycles.
  - DRAIN starts at T+1+TEST_COUNT*(3+SETTLE_CYCLES).
  - With fit_ready held high, one score transfers per cycle.
  - done pulses at T+1+TEST_COUNT*(3+SETTLE_CYCLES)+POP_SIZE.
  - Defaults (TEST_COUNT=2, SETTLE_CYCLES=1, POP_SIZE=15): done at T+24.
- While fit_valid=1 and fit_ready=0, fit_index and fit_score stay stable. Stalls extend DRAIN one cycle each.
- fit_ready while fit_valid=0 has no effect.
- dut_out is sampled only in SCORE. Glitches during SETTLE are irrelevant.

## Test plan
- Perfect candidate:
  - Vectors {0001,0001,0000,0001 | 0000,0000,0000,0001} and {0001,0000,0001,0001 | 0000,0000,0001,0001}.
  - Candidate 0 models the exact function.
  - Required: fit_index=0 gives fit_score=128, and done occurs at T+24.
- Inverted candidate: candidate 1 outputs ~expected on every vector. Required: fit_score=0 at fit_index=1.
- Constant-zero candidate on the vectors above:
  - Matches are 63 on the first vector and 62 on the second.
  - Required: fit_score=125. Verify all 15 indices arrive in order 0..14.
- Backpressure:
  - Drop fit_ready for 3 cycles while fit_index=4.
  - Required: index and score are held stable, and done is delayed by exactly 3 cycles (T+27).
- Start while busy:
  - Pulse start during SETTLE.
  - Required: no restart, same scores and timing as the single run.
  - A second start after done re-runs with accumulators cleared and gives identical scores.
- Reset mid-run:
  - rst=0 during SCORE of vector 0.
  - Required: next cycle busy=0, fit_valid=0, no done.
  - A new start then gives the unperturbed scores.

Source files
------------

// File: rtl/fitness_eval_sequencer.sv
// Scores a population of candidate circuits against a stored vector set and
// streams one accumulated bitwise-match score per candidate to the host.
module fitness_eval_sequencer #(
    parameter int POP_SIZE      = 15,
    parameter int TEST_COUNT    = 2,
    parameter int DATA_W        = 16,
    parameter int SETTLE_CYCLES = 1,
    localparam int FIT_W = $clog2(TEST_COUNT * 4 * DATA_W + 1),
    localparam int AW    = (TEST_COUNT > 1) ? $clog2(TEST_COUNT) : 1,
    localparam int IW    = (POP_SIZE > 1) ? $clog2(POP_SIZE) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic [AW-1:0]                  vec_addr,
    input  logic [8*DATA_W-1:0]            vec_rdata,
    output logic [4*DATA_W-1:0]            dut_in,
    input  logic [POP_SIZE*4*DATA_W-1:0]   dut_out,
    output logic                           busy,
    output logic                           fit_valid,
    input  logic                           fit_ready,
    output logic [IW-1:0]                  fit_index,
    output logic [FIT_W-1:0]               fit_score,
    output logic                           done,
    output logic [2:0]                     dbg_state
);

    localparam int CW = 4 * DATA_W;
    localparam int PW = $clog2(CW + 1);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_SETTLE = 3'd3,
        S_SCORE  = 3'd4,
        S_DRAIN  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t            state;
    logic [CW-1:0]     expected;
    logic [SW-1:0]     settle_cnt;
    logic [FIT_W-1:0]  acc       [POP_SIZE];
    logic [PW-1:0]     match_cnt [POP_SIZE];

    assign dbg_state = state;

    // Handshake: a score transfers on any rising edge where fit_valid and
    // fit_ready are both high; while fit_valid is high and fit_ready is low,
    // fit_index and fit_score hold. fit_ready is ignored when fit_valid is low.
    assign fit_score = acc[fit_index];

    // Per-candidate count of output bits that agree with the expected vector.
    always_comb begin
        logic [CW-1:0] match_vec;
        match_vec = '0;
        for (int i = 0; i < POP_SIZE; i++) begin
            match_cnt[i] = '0;
            match_vec    = ~(dut_out[i*CW +: CW] ^ expected);
            for (int b = 0; b < CW; b++) begin
                if (match_vec[b]) begin
                    match_cnt[i] = match_cnt[i] + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            fit_valid  <= 1'b0;
            fit_index  <= '0;
            vec_addr   <= '0;
            dut_in     <= '0;
            expected   <= '0;
            settle_cnt <= '0;
            for (int i = 0; i < POP_SIZE; i++) begin
                acc[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_FETCH;
                        busy     <= 1'b1;
                        vec_addr <= '0;
                        for (int i = 0; i < POP_SIZE; i++) begin
                            acc[i] <= '0;
                        end
                    end
                end
                // Memory read data arrives one cycle after the address.
                S_FETCH: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    dut_in     <= vec_rdata[8*DATA_W-1:CW];
                    expected   <= vec_rdata[CW-1:0];
                    settle_cnt <= SW'(SETTLE_CYCLES - 1);
                    state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= S_SCORE;
                    end else begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end
                end
                // vec_addr doubles as the vector counter.
                S_SCORE: begin
                    for (int i = 0; i < POP_SIZE; i++) begin
                        acc[i] <= acc[i] + FIT_W'(match_cnt[i]);
                    end
                    if (vec_addr == AW'(TEST_COUNT - 1)) begin
                        fit_index <= '0;
                        fit_valid <= 1'b1;
                        state     <= S_DRAIN;
                    end else begin
                        vec_addr <= vec_addr + AW'(1);
                        state    <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (fit_ready) begin
                        if (fit_index == IW'(POP_SIZE - 1)) begin
                            fit_valid <= 1'b0;
                            fit_index <= '0;
                            done      <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            fit_index <= fit_index + IW'(1);
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
